// File: rtl/apple_pkg.sv
// rtl/apple_pkg.sv - shared types and constants for the apple placer
package apple_pkg;

    typedef enum logic [2:0] {
        SHOW,
        PICK,
        QUERY,
        SCAN,
        COMMIT,
        FULL
    } state_t;

    localparam int COL_W = 5;
    localparam int ROW_W = 4;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], ^(v & LFSR_TAPS)};
    endfunction

    function automatic logic [COL_W-1:0] cand_col(input logic [15:0] v);
        return v[4:0];
    endfunction

    function automatic logic [ROW_W-1:0] cand_row(input logic [15:0] v);
        return v[12:9];
    endfunction

endpackage

// File: rtl/apple_lfsr.sv
// rtl/apple_lfsr.sv - free-running 16-bit Fibonacci LFSR, async reset to the seed
module apple_lfsr
    import apple_pkg::*;
(
    input  logic        clk,
    input  logic        resetN,
    output logic [15:0] o_value
);

    logic [15:0] r_lfsr;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    assign o_value = r_lfsr;

endmodule

// File: rtl/apple_placer.sv
// rtl/apple_placer.sv - picks a free grid cell for the apple and publishes it on frame boundaries
// Optional eaten_count output enabled by APPLE_EATEN_COUNT_EN.
module apple_placer
    import apple_pkg::*;
#(
    parameter int GRID_W    = 20,
    parameter int GRID_H    = 15,
    parameter int CELL_SIZE = 32,
    parameter int MAX_TRIES = 16,
    parameter int INIT_COL  = 10,
    parameter int INIT_ROW  = 7
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             startOfFrame,
    input  logic             apple_eaten,
    output logic             occ_req,
    output logic [COL_W-1:0] occ_col,
    output logic [ROW_W-1:0] occ_row,
    input  logic             occ_ack,
    input  logic             occ_hit,
    output logic [31:0]      topLeft_x,
    output logic [31:0]      topLeft_y,
    output logic [31:0]      width,
    output logic [31:0]      hight,
    output logic             apple_valid,
    output logic             board_full
`ifdef APPLE_EATEN_COUNT_EN
    ,
    output logic [15:0]      eaten_count
`endif
);

    localparam int               TRY_W    = $clog2(MAX_TRIES + 1);
    localparam logic [TRY_W-1:0] TRY_MAX  = TRY_W'(MAX_TRIES);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(GRID_W - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(GRID_H - 1);
    localparam logic [31:0]      CELL_PX  = 32'(CELL_SIZE);

    state_t           r_state, w_state_nxt;
    logic [15:0]      w_lfsr;
    logic [COL_W-1:0] w_cand_col;
    logic [ROW_W-1:0] w_cand_row;
    logic             w_cand_ok;
    logic             w_eat_accept;
    logic [TRY_W-1:0] w_tries_inc;

    logic             r_occ_req;
    logic [COL_W-1:0] r_occ_col, r_scan_col, r_pend_col;
    logic [ROW_W-1:0] r_occ_row, r_scan_row, r_pend_row;
    logic [TRY_W-1:0] r_tries;
    logic             r_scan_mode, r_scan_last, r_pend_valid;
    logic [31:0]      r_top_x, r_top_y;
    logic             r_apple_valid, r_board_full;

    apple_lfsr u_lfsr (
        .clk     (clk),
        .resetN  (resetN),
        .o_value (w_lfsr)
    );

    assign w_cand_col   = cand_col(w_lfsr);
    assign w_cand_row   = cand_row(w_lfsr);
    assign w_cand_ok    = (w_cand_col <= LAST_COL) && (w_cand_row <= LAST_ROW);
    assign w_eat_accept = (r_state == SHOW) && apple_eaten;
    assign w_tries_inc  = r_tries + 1'b1;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state <= SHOW;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SHOW:   if (apple_eaten) w_state_nxt = PICK;
            PICK:   if (w_cand_ok) w_state_nxt = QUERY;
            QUERY: begin
                if (occ_ack) begin
                    if (!occ_hit)                  w_state_nxt = COMMIT;
                    else if (r_scan_mode)          w_state_nxt = SCAN;
                    else if (w_tries_inc == TRY_MAX) w_state_nxt = SCAN;
                    else                           w_state_nxt = PICK;
                end
            end
            SCAN:   w_state_nxt = r_scan_last ? FULL : QUERY;
            COMMIT: if (startOfFrame) w_state_nxt = SHOW;
            FULL:   w_state_nxt = FULL;
            default: w_state_nxt = SHOW;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_occ_req     <= 1'b0;
            r_occ_col     <= '0;
            r_occ_row     <= '0;
            r_scan_col    <= '0;
            r_scan_row    <= '0;
            r_pend_col    <= '0;
            r_pend_row    <= '0;
            r_tries       <= '0;
            r_scan_mode   <= 1'b0;
            r_scan_last   <= 1'b0;
            r_pend_valid  <= 1'b0;
            r_top_x       <= 32'(INIT_COL * CELL_SIZE);
            r_top_y       <= 32'(INIT_ROW * CELL_SIZE);
            r_apple_valid <= 1'b1;
            r_board_full  <= 1'b0;
        end else begin
            case (r_state)
                SHOW: begin
                    if (w_eat_accept) begin
                        r_apple_valid <= 1'b0;
                        r_tries       <= '0;
                        r_scan_mode   <= 1'b0;
                        r_scan_last   <= 1'b0;
                    end
                end
                PICK: begin
                    if (w_cand_ok) begin
                        r_occ_col <= w_cand_col;
                        r_occ_row <= w_cand_row;
                        r_occ_req <= 1'b1;
                    end
                end
                QUERY: begin
                    if (occ_ack) begin
                        r_occ_req <= 1'b0;
                        if (!occ_hit) begin
                            r_pend_col   <= r_occ_col;
                            r_pend_row   <= r_occ_row;
                            r_pend_valid <= 1'b1;
                        end else if (r_scan_mode) begin
                            // The query registers hold the scan cell just tested
                            if (r_occ_col == LAST_COL) begin
                                if (r_occ_row == LAST_ROW) begin
                                    r_scan_last <= 1'b1;
                                end else begin
                                    r_scan_col <= '0;
                                    r_scan_row <= r_occ_row + 1'b1;
                                end
                            end else begin
                                r_scan_col <= r_occ_col + 1'b1;
                            end
                        end else begin
                            r_tries <= w_tries_inc;
                            if (w_tries_inc == TRY_MAX) begin
                                r_scan_mode <= 1'b1;
                                r_scan_col  <= '0;
                                r_scan_row  <= '0;
                            end
                        end
                    end
                end
                SCAN: begin
                    if (r_scan_last) begin
                        r_board_full <= 1'b1;
                    end else begin
                        r_occ_col <= r_scan_col;
                        r_occ_row <= r_scan_row;
                        r_occ_req <= 1'b1;
                    end
                end
                COMMIT: begin
                    if (startOfFrame) begin
                        r_top_x       <= 32'(r_pend_col) * CELL_PX;
                        r_top_y       <= 32'(r_pend_row) * CELL_PX;
                        r_apple_valid <= 1'b1;
                        r_pend_valid  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef APPLE_EATEN_COUNT_EN
    logic [15:0] r_eaten_count;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_eaten_count <= '0;
        end else if (w_eat_accept && (r_eaten_count != 16'hFFFF)) begin
            r_eaten_count <= r_eaten_count + 16'd1;
        end
    end

    assign eaten_count = r_eaten_count;
`endif

    assign occ_req     = r_occ_req;
    assign occ_col     = r_occ_col;
    assign occ_row     = r_occ_row;
    assign topLeft_x   = r_top_x;
    assign topLeft_y   = r_top_y;
    assign width       = CELL_PX - 32'd1;
    assign hight       = CELL_PX - 32'd1;
    assign apple_valid = r_apple_valid;
    assign board_full  = r_board_full;

endmodule

// File: tb/tb_apple_placer.sv
// tb/tb_apple_placer.sv - randomized self-checking bench for apple_placer against an occupancy/placement model
module tb_apple_placer;

    localparam int GW = 20;
    localparam int GH = 15;
    localparam int CS = 32;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        startOfFrame = 1'b0;
    logic        apple_eaten = 1'b0;
    logic        occ_ack = 1'b0;
    logic        occ_hit = 1'b0;
    logic        occ_req;
    logic [4:0]  occ_col;
    logic [3:0]  occ_row;
    logic [31:0] topLeft_x, topLeft_y, width, hight;
    logic        apple_valid, board_full;
`ifdef APPLE_EATEN_COUNT_EN
    logic [15:0] eaten_count;
`endif

    int checks = 0;
    int errors = 0;
    int exp_x = 320;
    int exp_y = 224;
    int exp_count = 0;

    apple_placer dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .apple_eaten  (apple_eaten),
        .occ_req      (occ_req),
        .occ_col      (occ_col),
        .occ_row      (occ_row),
        .occ_ack      (occ_ack),
        .occ_hit      (occ_hit),
        .topLeft_x    (topLeft_x),
        .topLeft_y    (topLeft_y),
        .width        (width),
        .hight        (hight),
        .apple_valid  (apple_valid),
        .board_full   (board_full)
`ifdef APPLE_EATEN_COUNT_EN
        ,
        .eaten_count  (eaten_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Snake occupancy scenarios: 0 all free, 1 first three queries hit,
    // 2 everything but (3,2) occupied, 3 board completely occupied
    function automatic bit occupied(input int mode, input int col, input int row, input int qidx);
        case (mode)
            1:       return qidx < 3;
            2:       return !(col == 3 && row == 2);
            3:       return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_x"}, topLeft_x, exp_x);
        chk({tag, "_y"}, topLeft_y, exp_y);
        chk({tag, "_req"}, occ_req, 0);
`ifdef APPLE_EATEN_COUNT_EN
        chk({tag, "_count"}, eaten_count, exp_count);
`endif
    endtask

    task automatic eat_and_serve(input int mode, input int dly, input bit sof_with_ack, output int nq);
        int col, row, fcol, frow, wait_c;
        bit hit, found, full_seen;
        @(negedge clk) apple_eaten = 1'b1;
        @(negedge clk) apple_eaten = 1'b0;
        exp_count++;
        chk("eat_valid_low", apple_valid, 0);
        nq = 0; found = 0; full_seen = 0; fcol = 0; frow = 0;
        while (!found && !full_seen) begin
            wait_c = 0;
            while (!occ_req && !board_full && wait_c < 100) begin
                @(negedge clk);
                wait_c++;
            end
            if (board_full) begin
                full_seen = 1'b1;
            end else if (!occ_req) begin
                chk("req_timeout", occ_req, 1);
                return;
            end else begin
                col = int'(occ_col);
                row = int'(occ_row);
                chk("col_range", (col < GW), 1);
                chk("row_range", (row < GH), 1);
                if (mode >= 2 && nq >= 16) begin
                    chk("scan_col", col, (nq - 16) % GW);
                    chk("scan_row", row, (nq - 16) / GW);
                end
                hit = occupied(mode, col, row, nq);
                repeat (dly) begin
                    @(negedge clk);
                    chk("hold_req", occ_req, 1);
                    chk("hold_col", occ_col, col);
                    chk("hold_row", occ_row, row);
                end
                occ_ack = 1'b1;
                occ_hit = hit;
                if (!hit && sof_with_ack) startOfFrame = 1'b1;
                @(negedge clk);
                occ_ack = 1'b0;
                occ_hit = 1'b0;
                startOfFrame = 1'b0;
                chk("req_drop", occ_req, 0);
                nq++;
                if (!hit) begin
                    found = 1'b1;
                    fcol = col;
                    frow = row;
                end
            end
        end
        if (found) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            chk("pre_sof_valid", apple_valid, 0);
            chk("pre_sof_x", topLeft_x, exp_x);
            chk("pre_sof_y", topLeft_y, exp_y);
            startOfFrame = 1'b1;
            @(negedge clk) startOfFrame = 1'b0;
            exp_x = fcol * CS;
            exp_y = frow * CS;
            chk("commit_valid", apple_valid, 1);
            chk("commit_x", topLeft_x, exp_x);
            chk("commit_y", topLeft_y, exp_y);
            chk("commit_pend", dut.r_pend_valid, 0);
        end
    endtask

    initial begin
        int nq;
        repeat (3) @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);
        chk("rst_valid", apple_valid, 1);
        chk("rst_full", board_full, 0);
        chk("rst_width", width, 31);
        chk("rst_hight", hight, 31);
        check_idle_outputs("rst");

        for (int i = 0; i < 4; i++) begin
            eat_and_serve(0, $urandom_range(0, 5), (i == 1), nq);
            chk("free_nq", nq, 1);
        end

        eat_and_serve(1, 5, 1'b0, nq);
        chk("three_hits_nq", nq, 4);

        eat_and_serve(2, $urandom_range(0, 1), 1'b0, nq);
        chk("scan_commit_x", topLeft_x, 96);
        chk("scan_commit_y", topLeft_y, 64);
        if (nq > 16) chk("scan_nq", nq, 16 + 2 * GW + 3 + 1);
        check_idle_outputs("after_scan");

        // Reset while a query is outstanding; the late ack must be ignored
        @(negedge clk) apple_eaten = 1'b1;
        @(negedge clk) apple_eaten = 1'b0;
        repeat (50) begin
            if (!occ_req) @(negedge clk);
        end
        chk("mid_req_up", occ_req, 1);
        resetN = 1'b0;
        #1;
        exp_x = 320; exp_y = 224; exp_count = 0;
        chk("mid_rst_req", occ_req, 0);
        chk("mid_rst_valid", apple_valid, 1);
        @(negedge clk) resetN = 1'b1;
        occ_ack = 1'b1;
        occ_hit = 1'b0;
        @(negedge clk) occ_ack = 1'b0;
        startOfFrame = 1'b1;
        @(negedge clk) startOfFrame = 1'b0;
        chk("late_ack_valid", apple_valid, 1);
        check_idle_outputs("late_ack");

        eat_and_serve(3, 0, 1'b0, nq);
        chk("full_nq", nq, 16 + GW * GH);
        chk("full_flag", board_full, 1);
        chk("full_valid", apple_valid, 0);
        @(negedge clk) apple_eaten = 1'b1;
        @(negedge clk) apple_eaten = 1'b0;
        repeat (4) @(negedge clk);
        chk("full_hold_flag", board_full, 1);
        chk("full_hold_valid", apple_valid, 0);
        check_idle_outputs("full_hold");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
